// File: rtl/knn_dist_engine_if.sv
// Point-stream, control and read-port bundle for knn_dist_engine.
// The engine connects through the slave modport; the feeder/reader side uses master.
interface knn_dist_engine_if #(
  parameter int COORD_W = 16,
  parameter int DIMS    = 2,
  parameter int ADDR_W  = 6
);
  localparam int DIST_W = 2*COORD_W + 1 + $clog2(DIMS);

  logic                      start;
  logic [DIMS*COORD_W-1:0]   test_pt;
  logic                      pt_valid;
  logic                      pt_ready;
  logic [DIMS*COORD_W-1:0]   pt_data;
  logic                      pt_last;
  logic                      busy;
  logic                      done;
  logic [ADDR_W:0]           pt_count;
  logic                      rd_en;
  logic [ADDR_W-1:0]         rd_addr;
  logic [DIST_W-1:0]         rd_data;
  logic [DIST_W-1:0]         min_dist;
  logic [ADDR_W-1:0]         min_idx;

  modport master (
    output start, test_pt, pt_valid, pt_data, pt_last, rd_en, rd_addr,
    input  pt_ready, busy, done, pt_count, rd_data, min_dist, min_idx
  );

  modport slave (
    input  start, test_pt, pt_valid, pt_data, pt_last, rd_en, rd_addr,
    output pt_ready, busy, done, pt_count, rd_data, min_dist, min_idx
  );
endinterface

// File: rtl/knn_dist_engine.sv
// Pipelined squared-Euclidean distance engine writing results into a readable distance memory.
// Optional running-minimum tracking is enabled by defining KNN_MIN_TRACK_EN.
module knn_dist_engine #(
  parameter int COORD_W = 16,
  parameter int DIMS    = 2,
  parameter int DEPTH   = 64,
  parameter int ADDR_W  = 6
) (
  input  logic             clk,
  input  logic             rst,
  knn_dist_engine_if.slave bus
);
  localparam int DIST_W = 2*COORD_W + 1 + $clog2(DIMS);
  localparam int SQ_W   = 2*COORD_W + 1;
  localparam int CNT_W  = ADDR_W + 1;

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

  state_t                  state_reg, state_next;
  logic [DIMS*COORD_W-1:0] test_reg;
  logic [CNT_W-1:0]        acc_cnt_reg;
  logic [CNT_W-1:0]        wr_cnt_reg;
  logic                    v1_reg, v2_reg, v3_reg;
  logic [SQ_W-1:0]         sq_arr [DIMS];
  logic [DIST_W-1:0]       sum_next, sum_reg;
  logic [DIST_W-1:0]       mem [DEPTH];
  logic [DIST_W-1:0]       rd_data_reg;
  logic                    pt_ready;
  logic                    xfer;
  logic                    last_xfer;
  logic                    pipe_empty;
  logic                    wr_en;

  // start takes priority over any transfer offered in the same cycle
  assign pt_ready   = (state_reg == RUN) && !bus.start && (acc_cnt_reg < CNT_W'(DEPTH));
  assign xfer       = bus.pt_valid && pt_ready;
  assign last_xfer  = xfer && (bus.pt_last || (acc_cnt_reg == CNT_W'(DEPTH - 1)));
  assign pipe_empty = !(v1_reg || v2_reg || v3_reg);
  assign wr_en      = v3_reg && !bus.start;

  always_comb begin
    state_next = state_reg;
    if (bus.start) begin
      state_next = RUN;
    end else begin
      case (state_reg)
        RUN:     if (last_xfer)  state_next = DRAIN;
        DRAIN:   if (pipe_empty) state_next = DONE;
        default: state_next = state_reg;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg   <= IDLE;
      test_reg    <= '0;
      acc_cnt_reg <= '0;
      wr_cnt_reg  <= '0;
      v1_reg      <= 1'b0;
      v2_reg      <= 1'b0;
      v3_reg      <= 1'b0;
    end else begin
      state_reg <= state_next;
      if (bus.start) begin
        // restart drops everything in flight
        test_reg    <= bus.test_pt;
        acc_cnt_reg <= '0;
        wr_cnt_reg  <= '0;
        v1_reg      <= 1'b0;
        v2_reg      <= 1'b0;
        v3_reg      <= 1'b0;
      end else begin
        v1_reg <= xfer;
        v2_reg <= v1_reg;
        v3_reg <= v2_reg;
        if (xfer)  acc_cnt_reg <= acc_cnt_reg + CNT_W'(1);
        if (wr_en) wr_cnt_reg  <= wr_cnt_reg + CNT_W'(1);
      end
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < DIMS; gi++) begin : g_dim
      localparam logic [COORD_W:0] ONE_D = 1;
      logic [COORD_W-1:0] p_c, t_c;
      logic [COORD_W:0]   diff_reg;
      logic [COORD_W:0]   mag;
      logic [SQ_W-1:0]    mag_ext;
      logic [SQ_W-1:0]    sq_reg;

      assign p_c     = bus.pt_data[gi*COORD_W +: COORD_W];
      assign t_c     = test_reg[gi*COORD_W +: COORD_W];
      // magnitude of the sign-extended difference; |-2^COORD_W| still fits unsigned
      assign mag     = diff_reg[COORD_W] ? ((~diff_reg) + ONE_D) : diff_reg;
      assign mag_ext = SQ_W'(mag);

      always_ff @(posedge clk) begin
        diff_reg <= {p_c[COORD_W-1], p_c} - {t_c[COORD_W-1], t_c};
        sq_reg   <= mag_ext * mag_ext;
      end

      assign sq_arr[gi] = sq_reg;
    end
  endgenerate

  always_comb begin
    sum_next = '0;
    for (int d = 0; d < DIMS; d++) begin
      sum_next = sum_next + DIST_W'(sq_arr[d]);
    end
  end

  always_ff @(posedge clk) begin
    sum_reg <= sum_next;
  end

  // distance memory, deliberately not reset
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_cnt_reg[ADDR_W-1:0]] <= sum_reg;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)             rd_data_reg <= '0;
    else if (bus.rd_en)  rd_data_reg <= mem[bus.rd_addr];
  end

`ifdef KNN_MIN_TRACK_EN
  logic [DIST_W-1:0] min_dist_reg;
  logic [ADDR_W-1:0] min_idx_reg;

  // strict compare so ties keep the earlier index
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      min_dist_reg <= '1;
      min_idx_reg  <= '0;
    end else if (bus.start) begin
      min_dist_reg <= '1;
      min_idx_reg  <= '0;
    end else if (wr_en && (sum_reg < min_dist_reg)) begin
      min_dist_reg <= sum_reg;
      min_idx_reg  <= wr_cnt_reg[ADDR_W-1:0];
    end
  end

  assign bus.min_dist = min_dist_reg;
  assign bus.min_idx  = min_idx_reg;
`else
  assign bus.min_dist = '0;
  assign bus.min_idx  = '0;
`endif

  assign bus.pt_ready = pt_ready;
  assign bus.busy     = (state_reg == RUN) || (state_reg == DRAIN);
  assign bus.done     = (state_reg == DONE);
  assign bus.pt_count = wr_cnt_reg;
  assign bus.rd_data  = rd_data_reg;
endmodule

// File: tb/tb_knn_dist_engine.sv
// Self-checking bench for knn_dist_engine: vector table, corner sequences and
// randomized runs compared against an arithmetic distance model.
module tb_knn_dist_engine;
  localparam int COORD_W = 16;
  localparam int DIMS    = 2;
  localparam int DEPTH   = 64;
  localparam int ADDR_W  = 6;
  localparam int DIST_W  = 2*COORD_W + 1 + $clog2(DIMS);
  localparam longint ALL1 = (longint'(1) << DIST_W) - 1;

  logic clk = 1'b0;
  logic rst = 1'b1;

  knn_dist_engine_if #(.COORD_W(COORD_W), .DIMS(DIMS), .ADDR_W(ADDR_W)) bus ();

  knn_dist_engine #(.COORD_W(COORD_W), .DIMS(DIMS), .DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  int     checks = 0;
  int     errors = 0;
  longint mem_model [DEPTH];

  typedef struct {
    int     tx, ty, px, py;
    longint exp;
  } vec_t;

  function automatic logic [DIMS*COORD_W-1:0] mk(input int x, input int y);
    logic [COORD_W-1:0] xs, ys;
    xs = COORD_W'(x);
    ys = COORD_W'(y);
    return {ys, xs};
  endfunction

  // plain integer arithmetic over signed coordinates
  function automatic longint ref_dist(input logic [DIMS*COORD_W-1:0] tp, input logic [DIMS*COORD_W-1:0] p);
    longint acc;
    logic signed [COORD_W-1:0] a, b;
    longint diff;
    acc = 0;
    for (int d = 0; d < DIMS; d++) begin
      a    = p[d*COORD_W +: COORD_W];
      b    = tp[d*COORD_W +: COORD_W];
      diff = longint'(a) - longint'(b);
      acc  = acc + diff * diff;
    end
    return acc;
  endfunction

  task automatic check(input string name, input longint act, input longint exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end else begin
      $display("ok   %s value=%0d", name, act);
    end
  endtask

  task automatic do_start(input logic [DIMS*COORD_W-1:0] tp);
    @(negedge clk);
    bus.start   = 1'b1;
    bus.test_pt = tp;
    @(negedge clk);
    bus.start   = 1'b0;
  endtask

  // offers one point and returns at the negedge after it was accepted
  task automatic send(input logic [DIMS*COORD_W-1:0] p, input bit last);
    int  n;
    bit  got;
    n   = 0;
    got = 0;
    bus.pt_valid = 1'b1;
    bus.pt_data  = p;
    bus.pt_last  = last;
    while (!got && n < 200) begin
      #1;
      if (bus.pt_ready) got = 1;
      @(negedge clk);
      n++;
    end
    if (!got) begin
      checks++;
      errors++;
      $display("FAIL send_timeout actual=%0d required=1", bus.pt_ready);
    end
    bus.pt_valid = 1'b0;
    bus.pt_last  = 1'b0;
  endtask

  task automatic wait_done(output int cyc);
    cyc = 0;
    while (!bus.done && cyc < 300) begin
      @(negedge clk);
      cyc++;
    end
    if (!bus.done) begin
      checks++;
      errors++;
      $display("FAIL done_timeout actual=%0d required=1", bus.done);
    end
  endtask

  task automatic read_mem(input int addr, output longint v);
    @(negedge clk);
    bus.rd_en   = 1'b1;
    bus.rd_addr = ADDR_W'(addr);
    @(negedge clk);
    v = longint'(bus.rd_data);
    bus.rd_en = 1'b0;
  endtask

  // random run of n points; gaps between offers are random, bursts are back-to-back
  task automatic run_random(input int n, input bit use_last, input string tag);
    logic [DIMS*COORD_W-1:0] tp;
    logic [DIMS*COORD_W-1:0] pts [DEPTH];
    longint v;
    int cyc;
    tp = DIMS*COORD_W'($urandom);
    do_start(tp);
    for (int i = 0; i < n; i++) begin
      pts[i] = DIMS*COORD_W'($urandom);
      if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 3)) @(negedge clk);
      send(pts[i], use_last && (i == n - 1));
    end
    #1;
    check({tag, "_ready_low"}, longint'(bus.pt_ready), 0);
    wait_done(cyc);
    check({tag, "_count"}, longint'(bus.pt_count), n);
    for (int i = 0; i < n; i++) begin
      mem_model[i] = ref_dist(tp, pts[i]);
      read_mem(i, v);
      check($sformatf("%s_mem%0d", tag, i), v, mem_model[i]);
    end
  endtask

  vec_t tbl [7];

  initial begin
    #500000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1);
  end

  initial begin
    longint v;
    int cyc;

    tbl[0] = '{3, 4, 0, 0, 25};
    tbl[1] = '{32767, 32767, -32768, -32768, 64'd8589672450};
    tbl[2] = '{0, 0, 0, 0, 0};
    tbl[3] = '{-32768, -32768, 32767, 32767, 64'd8589672450};
    tbl[4] = '{100, -200, -50, 25, 73125};
    tbl[5] = '{-1, 1, 1, -1, 8};
    tbl[6] = '{-32768, 0, 32767, 0, 64'd4294836225};

    bus.start = 0; bus.test_pt = '0; bus.pt_valid = 0; bus.pt_data = '0;
    bus.pt_last = 0; bus.rd_en = 0; bus.rd_addr = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    #1;
    check("rst_pt_ready", longint'(bus.pt_ready), 0);
    check("rst_busy",     longint'(bus.busy), 0);
    check("rst_done",     longint'(bus.done), 0);
    check("rst_pt_count", longint'(bus.pt_count), 0);
    check("rst_rd_data",  longint'(bus.rd_data), 0);
`ifdef KNN_MIN_TRACK_EN
    check("rst_min_dist", longint'(bus.min_dist), ALL1);
`else
    check("rst_min_dist", longint'(bus.min_dist), 0);
`endif
    check("rst_min_idx",  longint'(bus.min_idx), 0);

    // single-point runs with exact latency checks
    for (int i = 0; i < 7; i++) begin
      do_start(mk(tbl[i].tx, tbl[i].ty));
      send(mk(tbl[i].px, tbl[i].py), 1'b1);
      repeat (2) @(negedge clk);
      check($sformatf("vec%0d_count_pre", i), longint'(bus.pt_count), 0);
      @(negedge clk);
      check($sformatf("vec%0d_count_post", i), longint'(bus.pt_count), 1);
      check($sformatf("vec%0d_done_early", i), longint'(bus.done), 0);
      @(negedge clk);
      check($sformatf("vec%0d_done", i), longint'(bus.done), 1);
      read_mem(0, v);
      check($sformatf("vec%0d_dist", i), v, tbl[i].exp);
      mem_model[0] = tbl[i].exp;
    end

    // three back-to-back points, last on the third
    do_start(mk(3, 4));
    send(mk(0, 0), 1'b0);
    send(mk(3, 4), 1'b0);
    send(mk(-3, -4), 1'b1);
    wait_done(cyc);
    check("seq3_done_latency", cyc, 4);
    check("seq3_count", longint'(bus.pt_count), 3);
    mem_model[0] = 25; mem_model[1] = 0; mem_model[2] = 100;
    for (int i = 0; i < 3; i++) begin
      read_mem(i, v);
      check($sformatf("seq3_mem%0d", i), v, mem_model[i]);
    end

    // restart one cycle after two accepts, with a point offered alongside start
    do_start(mk(1000, -1000));
    send(mk(-1000, 1000), 1'b0);
    send(mk(500, 500), 1'b0);
    bus.start    = 1'b1;
    bus.test_pt  = mk(7, 7);
    bus.pt_valid = 1'b1;
    bus.pt_data  = mk(-9, -9);
    bus.pt_last  = 1'b1;
    #1;
    check("restart_ready_with_start", longint'(bus.pt_ready), 0);
    @(negedge clk);
    bus.start = 1'b0; bus.pt_valid = 1'b0; bus.pt_last = 1'b0;
    send(mk(10, 11), 1'b1);
    wait_done(cyc);
    check("restart_count", longint'(bus.pt_count), 1);
    read_mem(1, v);
    check("restart_mem1_untouched", v, mem_model[1]);
    mem_model[0] = 9 + 16;
    read_mem(0, v);
    check("restart_mem0", v, mem_model[0]);

    // asynchronous reset with points in flight
    do_start(mk(20, 20));
    send(mk(1, 1), 1'b0);
    send(mk(2, 2), 1'b0);
    #2 rst = 1'b1;
    #1;
    check("arst_busy", longint'(bus.busy), 0);
    check("arst_ready", longint'(bus.pt_ready), 0);
    check("arst_rd_data", longint'(bus.rd_data), 0);
    @(negedge clk);
    rst = 1'b0;
    repeat (5) @(negedge clk);
    check("arst_count", longint'(bus.pt_count), 0);
    read_mem(0, v);
    check("arst_mem0_kept", v, mem_model[0]);

    // full DEPTH without pt_last, then randomized bursty run
    run_random(DEPTH, 1'b0, "depth");
    run_random(40, 1'b1, "rand");

    // running minimum with a tie
    do_start(mk(0, 0));
    send(mk(5, 5), 1'b0);
    send(mk(3, 0), 1'b0);
    send(mk(0, 3), 1'b0);
    send(mk(6, 2), 1'b1);
    wait_done(cyc);
    check("min_count", longint'(bus.pt_count), 4);
`ifdef KNN_MIN_TRACK_EN
    check("min_dist", longint'(bus.min_dist), 9);
    check("min_idx",  longint'(bus.min_idx), 1);
`else
    check("min_dist", longint'(bus.min_dist), 0);
    check("min_idx",  longint'(bus.min_idx), 0);
`endif
    read_mem(3, v);
    check("min_mem3", v, 40);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
